apb_uart_arbiter: RTL and testbench
===================================

Name: apb_uart_arbiter

Overview:
Shares the single apb_uart slave port between NrReq APB requesters, e.g. the ara_soc UART port and an FPGA host/VIO loader port. Uses round-robin arbitration at transfer granularity. Drives the downstream APB master through SETUP/ACCESS, routes the response back to the granted requester only, and converts a hung slave into a PSLVERR via a watchdog. Sits in the FPGA top between ara_soc and apb_uart, on the divided soc clock.

Parameters:
NrReq, 2, number of upstream APB requesters (>=2)
AddrWidth, 32, APB address width
DataWidth, 32, APB data width
TimeoutCycles, 1024, max ACCESS cycles without PREADY before error completion (>=2)

Ports:
clk_i  in  1  SoC clock
rst_i  in  1  reset, synchronous, active-high
req_psel_i  in  NrReq  per-requester PSEL
req_penable_i  in  NrReq  per-requester PENABLE
req_pwrite_i  in  NrReq  per-requester PWRITE
req_paddr_i  in  NrReq x AddrWidth  per-requester PADDR
req_pwdata_i  in  NrReq x DataWidth  per-requester PWDATA
req_prdata_o  out  NrReq x DataWidth  per-requester PRDATA
req_pready_o  out  NrReq  per-requester PREADY
req_pslverr_o  out  NrReq  per-requester PSLVERR
m_psel_o  out  1  to slave
m_penable_o  out  1  to slave
m_pwrite_o  out  1  to slave
m_paddr_o  out  AddrWidth  to slave (top slices [4:2])
m_pwdata_o  out  DataWidth  to slave
m_prdata_i  in  DataWidth  from slave
m_pready_i  in  1  from slave
m_pslverr_i  in  1  from slave
grant_o  out  NrReq  one-hot current owner, 0 when IDLE (debug/ILA)
timeout_o  out  1  one-cycle pulse on watchdog completion

Behaviour:
- Reset (rst_i=1 at posedge): state=IDLE, rr pointer=0, watchdog=0. All outputs 0.
- FSM IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - Candidates = req_psel_i; penable is ignored.
  - If any candidate exists, grant the first set bit searching from pointer upward with wrap.
  - Latch grant index, pwrite, paddr, pwdata. Go to SETUP.
  - m_psel_o=0 in IDLE.
- SETUP: m_psel_o=1, m_penable_o=0, driven from latched values. Always 1 cycle, then ACCESS.
- ACCESS:
  - m_psel_o=1, m_penable_o=1. Watchdog increments each cycle.
  - If m_pready_i=1: combinationally drive req_pready_o[g]=1, req_prdata_o[g]=m_prdata_i, req_pslverr_o[g]=m_pslverr_i. Then pointer=(g+1) mod NrReq, watchdog=0, go to IDLE.
  - Else if watchdog==TimeoutCycles-1: req_pready_o[g]=1, req_pslverr_o[g]=1, req_prdata_o[g]=0, timeout_o=1. Pointer advances as above, go to IDLE. Slave is abandoned: m_psel_o low next cycle.
- Non-granted requesters see pready=0, prdata=0, pslverr=0 at all times.
- Latency: request seen in IDLE at cycle t gives m_psel at t+1, m_penable at t+2. With a zero-wait slave, req_pready is high at t+2. Minimum 3 cycles per transfer; one mandatory IDLE cycle between transfers.
- Latched address/data/write are stable through SETUP/ACCESS regardless of requester inputs.
- Requester deasserts psel mid-transfer (protocol violation): the transfer to the slave still completes; the response is still driven on the requester's pready for that cycle; no other effect.
- Simultaneous requests: strictly round-robin. A requester continuously holding psel cannot starve others.
- Single requester: granted back-to-back every 3 cycles.
- Watchdog width $clog2(TimeoutCycles). It never wraps: it is cleared on every ACCESS exit.
- Reset asserted mid-transfer: immediate return to IDLE on that edge. No pready is issued to the owner, and m_psel drops.

Decomposition:
- Package apb_uart_arb_pkg: state enum (IDLE, SETUP, ACCESS) and the default TimeoutCycles constant.
- Sub-module apb_rr_picker: combinational round-robin pick. Inputs are the req vector and pointer; outputs are valid and the one-hot/index grant. Pointer register stays in the parent.

Test Plan:
- Single write: req0 psel, addr 0x0000_000C, wdata 0x83, slave pready at first ACCESS -> m_paddr=0xC, m_pwdata=0x83, m_psel at t+1, m_penable at t+2, req_pready_o=01 at t+2, grant_o=01.
- Contention: req0 and req1 both psel from reset -> grant order req0, req1, req0, req1 over 4 transfers; each transfer 3 cycles plus IDLE gap; non-owner pready stays 0.
- Wait states and read: slave holds pready low 5 cycles, returns prdata 0xA5, pslverr=0 -> req1 receives 0xA5 on the pready cycle; req0 outputs stay 0; latched addr stable during the wait.
- Timeout: TimeoutCycles=8, slave never ready -> after 8 ACCESS cycles req_pready_o[g]=1, pslverr=1, prdata=0, timeout_o=1 for one cycle; next request is served normally.
- Slave error passthrough: m_pslverr_i=1 with pready -> owner sees pslverr=1, timeout_o=0.
- Reset mid-ACCESS: rst_i=1 during wait -> next cycle all outputs 0 and state IDLE; after release, req1 pending is granted first (pointer=0, req0 idle).

Source files
------------

// File: rtl/apb_uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_uart_arb_pkg
// Shared types and constants for the APB UART port arbiter.
//   arb_state_e          : transfer FSM state (IDLE -> SETUP -> ACCESS -> IDLE)
//   DefaultTimeoutCycles : default watchdog limit in ACCESS cycles
//   rr_next_idx          : round-robin successor of an index (wraps at n)
// -----------------------------------------------------------------------------
package apb_uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } arb_state_e;

   localparam int unsigned DefaultTimeoutCycles = 1024;

   function automatic int unsigned rr_next_idx(input int unsigned idx,
                                               input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// -----------------------------------------------------------------------------
// apb_rr_picker
// Combinational round-robin pick: grants the first set bit of req, searching
// upward from ptr and wrapping past NrReq-1 back to 0.
//   req    : request vector (one bit per requester)
//   ptr    : highest-priority index for this pick
//   valid  : at least one request present
//   onehot : one-hot grant (0 when !valid)
//   idx    : binary grant index (0 when !valid)
// -----------------------------------------------------------------------------
module apb_rr_picker #(
   parameter  int unsigned NrReq = 2,
   localparam int unsigned IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
   input  logic [NrReq-1:0] req,
   input  logic [IdxW-1:0]  ptr,
   output logic             valid,
   output logic [NrReq-1:0] onehot,
   output logic [IdxW-1:0]  idx
);

   int unsigned     cand;
   logic [IdxW-1:0] cand_idx;

   always_comb begin
      valid    = 1'b0;
      onehot   = '0;
      idx      = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < NrReq; k++) begin
         // Candidate k steps above the pointer, wrapped into range.
         cand = 32'(ptr) + k;
         if (cand >= NrReq) begin
            cand = cand - NrReq;
         end
         cand_idx = IdxW'(cand);
         if (!valid && req[cand_idx]) begin
            valid            = 1'b1;
            onehot[cand_idx] = 1'b1;
            idx              = cand_idx;
         end
      end
   end

endmodule

// File: rtl/apb_uart_arbiter.sv
// -----------------------------------------------------------------------------
// apb_uart_arbiter
// Shares one APB slave (apb_uart) between NrReq APB requesters. One transfer
// is owned at a time; ownership rotates round-robin per transfer. The owner's
// address/data/direction are captured in IDLE and replayed to the slave
// through SETUP and ACCESS, so requester-side changes mid-transfer have no
// effect. A watchdog turns a slave that never raises PREADY into an error
// completion (PSLVERR=1, PRDATA=0) after TimeoutCycles ACCESS cycles.
//
// Handshake: a requester asks by holding req_psel_i[i] (req_penable_i is not
// used). Its transfer is complete in the single cycle where req_pready_o[i]
// is high; prdata/pslverr are valid only in that cycle. Downstream, m_psel_o
// and m_penable_o follow standard APB SETUP/ACCESS, and the slave completes
// ACCESS by raising m_pready_i.
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_psel_i..pwdata_i    : upstream APB requests, one lane per requester
//   req_prdata_o..pslverr_o : upstream responses, only the owner's lane is
//                             ever non-zero
//   m_*                     : downstream APB master to the slave
//   grant_o                 : one-hot current owner, 0 in IDLE (debug)
//   timeout_o               : one-cycle pulse on watchdog completion
// -----------------------------------------------------------------------------
module apb_uart_arbiter
   import apb_uart_arb_pkg::*;
#(
   parameter int unsigned NrReq         = 2,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NrReq-1:0]                    req_psel_i,
   input  logic [NrReq-1:0]                    req_penable_i,
   input  logic [NrReq-1:0]                    req_pwrite_i,
   input  logic [NrReq-1:0][AddrWidth-1:0]     req_paddr_i,
   input  logic [NrReq-1:0][DataWidth-1:0]     req_pwdata_i,
   output logic [NrReq-1:0][DataWidth-1:0]     req_prdata_o,
   output logic [NrReq-1:0]                    req_pready_o,
   output logic [NrReq-1:0]                    req_pslverr_o,
   output logic                                m_psel_o,
   output logic                                m_penable_o,
   output logic                                m_pwrite_o,
   output logic [AddrWidth-1:0]                m_paddr_o,
   output logic [DataWidth-1:0]                m_pwdata_o,
   input  logic [DataWidth-1:0]                m_prdata_i,
   input  logic                                m_pready_i,
   input  logic                                m_pslverr_i,
   output logic [NrReq-1:0]                    grant_o,
   output logic                                timeout_o
);

   localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
   localparam int unsigned WdW  = $clog2(TimeoutCycles);
   localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);

   arb_state_e            state_q, state_d;
   logic [IdxW-1:0]       ptr_q, ptr_d;
   logic [WdW-1:0]        wd_q, wd_d;
   logic [IdxW-1:0]       gnt_q;
   logic [NrReq-1:0]      gnt_oh_q;
   logic                  pwrite_q;
   logic [AddrWidth-1:0]  paddr_q;
   logic [DataWidth-1:0]  pwdata_q;

   logic                  pick_valid;
   logic [NrReq-1:0]      pick_onehot;
   logic [IdxW-1:0]       pick_idx;

   logic                  load;
   logic                  busy;
   logic                  access;
   logic                  done;
   logic                  expired;
   logic                  resp_en;

   apb_rr_picker #(
      .NrReq (NrReq)
   ) u_picker (
      .req    (req_psel_i),
      .ptr    (ptr_q),
      .valid  (pick_valid),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         wd_q     <= '0;
         gnt_q    <= '0;
         gnt_oh_q <= '0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
         if (load) begin
            gnt_q    <= pick_idx;
            gnt_oh_q <= pick_onehot;
            pwrite_q <= req_pwrite_i[pick_idx];
            paddr_q  <= req_paddr_i[pick_idx];
            pwdata_q <= req_pwdata_i[pick_idx];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wd_d    = wd_q;
      load    = 1'b0;
      busy    = 1'b0;
      access  = 1'b0;
      done    = 1'b0;
      expired = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               load    = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            busy    = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            busy   = 1'b1;
            access = 1'b1;
            if (m_pready_i) begin
               done = 1'b1;
            end else if (wd_q == WdLast) begin
               // Slave is abandoned; the owner gets an error completion.
               done    = 1'b1;
               expired = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
            if (done) begin
               state_d = IDLE;
               wd_d    = '0;
               ptr_d   = IdxW'(rr_next_idx(32'(gnt_q), NrReq));
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Downstream master: replays the captured request while busy, 0 otherwise.
   // ---------------------------------------------------------------------------
   always_comb begin
      m_psel_o    = busy;
      m_penable_o = access;
      m_pwrite_o  = busy & pwrite_q;
      m_paddr_o   = busy ? paddr_q  : '0;
      m_pwdata_o  = busy ? pwdata_q : '0;
      grant_o     = busy ? gnt_oh_q : '0;
   end

   // ---------------------------------------------------------------------------
   // Upstream responses, routed to the owner only. A reset arriving in the
   // completing cycle suppresses the response, since the transfer is dropped.
   // ---------------------------------------------------------------------------
   assign resp_en = done & ~rst_i;

   always_comb begin
      req_pready_o  = '0;
      req_pslverr_o = '0;
      req_prdata_o  = '0;
      timeout_o     = expired & ~rst_i;
      for (int unsigned i = 0; i < NrReq; i++) begin
         req_pready_o[i]  = resp_en & gnt_oh_q[i];
         req_pslverr_o[i] = resp_en & gnt_oh_q[i] & (expired | m_pslverr_i);
         req_prdata_o[i]  = (resp_en & gnt_oh_q[i] & ~expired) ? m_prdata_i : '0;
      end
   end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_uart_arbiter
// Self-checking bench for apb_uart_arbiter (NrReq=2, TimeoutCycles=8).
// A small slave model answers after slave_wait ACCESS cycles, or never when
// slave_hang is set. Expected owner-side response bundles are pushed when a
// request is driven and popped when a PREADY shows up.
// -----------------------------------------------------------------------------
module tb_apb_uart_arbiter;

   localparam int NR  = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TO  = 8;
   // {pready[1:0], pslverr[1:0], timeout, paddr[7:0], prdata[1], prdata[0]}
   localparam int SBW = NR + NR + 1 + 8 + NR * DW;

   logic                   clk;
   logic                   rst;
   logic [NR-1:0]          req_psel;
   logic [NR-1:0]          req_penable;
   logic [NR-1:0]          req_pwrite;
   logic [NR-1:0][AW-1:0]  req_paddr;
   logic [NR-1:0][DW-1:0]  req_pwdata;
   logic [NR-1:0][DW-1:0]  req_prdata;
   logic [NR-1:0]          req_pready;
   logic [NR-1:0]          req_pslverr;
   logic                   m_psel;
   logic                   m_penable;
   logic                   m_pwrite;
   logic [AW-1:0]          m_paddr;
   logic [DW-1:0]          m_pwdata;
   logic [DW-1:0]          m_prdata;
   logic                   m_pready;
   logic                   m_pslverr;
   logic [NR-1:0]          grant;
   logic                   timeout;

   // Slave model controls
   int                     slave_wait;
   bit                     slave_hang;
   bit                     slave_err;
   logic [DW-1:0]          slave_rdata;
   int                     acc_cnt;

   logic [SBW-1:0]         exp_q[$];
   int                     checks;
   int                     errors;

   apb_uart_arbiter #(
      .NrReq         (NR),
      .AddrWidth     (AW),
      .DataWidth     (DW),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_psel_i    (req_psel),
      .req_penable_i (req_penable),
      .req_pwrite_i  (req_pwrite),
      .req_paddr_i   (req_paddr),
      .req_pwdata_i  (req_pwdata),
      .req_prdata_o  (req_prdata),
      .req_pready_o  (req_pready),
      .req_pslverr_o (req_pslverr),
      .m_psel_o      (m_psel),
      .m_penable_o   (m_penable),
      .m_pwrite_o    (m_pwrite),
      .m_paddr_o     (m_paddr),
      .m_pwdata_o    (m_pwdata),
      .m_prdata_i    (m_prdata),
      .m_pready_i    (m_pready),
      .m_pslverr_i   (m_pslverr),
      .grant_o       (grant),
      .timeout_o     (timeout)
   );

   // ---------------------------------------------------------------------------
   // Clock and slave model
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign m_pready  = m_psel && m_penable && !slave_hang && (acc_cnt >= slave_wait);
   assign m_prdata  = slave_rdata;
   assign m_pslverr = slave_err;

   always @(posedge clk) begin
      if (m_psel && m_penable && !m_pready) acc_cnt <= acc_cnt + 1;
      else                                  acc_cnt <= 0;
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int idx, input bit sel, input bit wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
      req_psel[idx]    = sel;
      req_penable[idx] = sel;
      req_pwrite[idx]  = wr;
      req_paddr[idx]   = addr;
      req_pwdata[idx]  = data;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Returns at the negedge of the first cycle with any PREADY; cycles counts
   // negedges elapsed before it (0 = the cycle the call started in).
   task automatic wait_resp(input int max_cycles, output bit got, output int cycles);
      got    = 1'b0;
      cycles = 0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (|req_pready) begin
            got    = 1'b1;
            cycles = i;
            return;
         end
      end
   endtask

   function automatic logic [SBW-1:0] make_exp(input int g, input bit err, input bit to,
                                               input logic [7:0] addr, input logic [DW-1:0] data);
      logic [NR-1:0]         rdy;
      logic [NR-1:0]         er;
      logic [NR-1:0][DW-1:0] pd;
      rdy     = '0;
      er      = '0;
      pd      = '0;
      rdy[g]  = 1'b1;
      er[g]   = err;
      pd[g]   = data;
      return {rdy, er, to, addr, pd};
   endfunction

   function automatic logic [SBW-1:0] observe();
      return {req_pready, req_pslverr, timeout, m_paddr[7:0], req_prdata};
   endfunction

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [SBW+NR+3+AW+DW-1:0] all_out;
      rst = 1'b1;
      step();
      step();
      @(negedge clk);
      all_out = {observe(), grant, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata};
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      all_out = {observe(), grant, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata};
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: got %h want 0", all_out);
      end
      step();
   endtask

   task automatic test_single_write();
      logic [SBW-1:0] obs, exp;
      logic [71:0]    setup_obs;
      slave_wait  = 0;
      slave_rdata = '0;
      set_req(0, 1'b1, 1'b1, 32'h0000_000C, 32'h0000_0083);
      exp_q.push_back(make_exp(0, 1'b0, 1'b0, 8'h0C, '0));
      // cycle t: IDLE
      @(negedge clk);
      checks++;
      if ({m_psel, grant} !== 3'b000) begin
         errors++;
         $display("FAIL single_t0: psel/grant got %b want 000", {m_psel, grant});
      end
      // cycle t+1: SETUP
      @(negedge clk);
      setup_obs = {m_psel, m_penable, m_pwrite, 3'b000, grant, m_paddr, m_pwdata};
      checks++;
      if (setup_obs !== {1'b1, 1'b0, 1'b1, 3'b000, 2'b01, 32'h0000_000C, 32'h0000_0083}) begin
         errors++;
         $display("FAIL single_setup: got %h", setup_obs);
      end
      // cycle t+2: ACCESS, zero-wait slave
      @(negedge clk);
      checks++;
      if ({m_psel, m_penable, grant} !== 4'b1101) begin
         errors++;
         $display("FAIL single_access: psel/penable/grant got %b want 1101",
                  {m_psel, m_penable, grant});
      end
      obs = observe();
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL single_resp: got %h want %h", obs, exp);
      end
      step();
      set_req(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      checks++;
      if ({m_psel, grant, req_pready} !== 5'b00000) begin
         errors++;
         $display("FAIL single_idle_gap: got %b want 00000", {m_psel, grant, req_pready});
      end
      step();
   endtask

   task automatic test_contention();
      logic [SBW-1:0] obs, exp;
      bit             got;
      int             cyc;
      apply_reset();
      slave_wait  = 0;
      slave_rdata = 32'h0000_0D00;
      set_req(0, 1'b1, 1'b0, 32'h0000_0004, '0);
      set_req(1, 1'b1, 1'b0, 32'h0000_0008, '0);
      for (int n = 0; n < 4; n++) begin
         exp_q.push_back(make_exp(n % 2, 1'b0, 1'b0, (n % 2) ? 8'h08 : 8'h04,
                                  32'h0000_0D00 + 32'(n)));
      end
      for (int n = 0; n < 4; n++) begin
         wait_resp(10, got, cyc);
         exp = exp_q.pop_front();
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL contention_%0d: no pready within 10 cycles", n);
         end else begin
            obs = observe();
            if (obs !== exp) begin
               errors++;
               $display("FAIL contention_%0d: got %h want %h", n, obs, exp);
            end
            checks++;
            if (cyc != 2) begin
               errors++;
               $display("FAIL contention_lat_%0d: got %0d want 2", n, cyc);
            end
         end
         step();
         slave_rdata = 32'h0000_0D00 + 32'(n + 1);
      end
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      step();
   endtask

   task automatic test_wait_read();
      logic [SBW-1:0] obs, exp;
      bit             got;
      int             waits;
      slave_wait  = 5;
      slave_rdata = 32'h0000_00A5;
      got         = 1'b0;
      waits       = 0;
      set_req(1, 1'b1, 1'b0, 32'h0000_0010, '0);
      exp_q.push_back(make_exp(1, 1'b0, 1'b0, 8'h10, 32'h0000_00A5));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (|req_pready) begin
            got = 1'b1;
            break;
         end
         if (m_penable) begin
            waits++;
            checks++;
            if ({m_paddr, req_prdata, req_pslverr} !== {32'h0000_0010, 66'd0}) begin
               errors++;
               $display("FAIL wait_hold_%0d: paddr %h prdata %h pslverr %b",
                        waits, m_paddr, req_prdata, req_pslverr);
            end
            req_paddr[1] = $urandom_range(32'h7FFF_FFFF, 32'h100);
         end
      end
      exp = exp_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL wait_read: no pready within 20 cycles");
      end else begin
         obs = observe();
         if (obs !== exp) begin
            errors++;
            $display("FAIL wait_read: got %h want %h", obs, exp);
         end
      end
      checks++;
      if (waits != 5) begin
         errors++;
         $display("FAIL wait_count: got %0d want 5", waits);
      end
      step();
      set_req(1, 1'b0, 1'b0, '0, '0);
      slave_wait = 0;
      step();
   endtask

   task automatic test_timeout();
      logic [SBW-1:0] obs, exp;
      bit             got;
      int             cyc;
      slave_hang  = 1'b1;
      slave_rdata = 32'hFFFF_FFFF;
      set_req(0, 1'b1, 1'b1, 32'h0000_0014, 32'h0000_0055);
      exp_q.push_back(make_exp(0, 1'b1, 1'b1, 8'h14, '0));
      wait_resp(40, got, cyc);
      exp = exp_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL timeout_resp: no pready within 40 cycles");
      end else begin
         obs = observe();
         if (obs !== exp) begin
            errors++;
            $display("FAIL timeout_resp: got %h want %h", obs, exp);
         end
         // IDLE, SETUP, then the 8th ACCESS cycle completes.
         checks++;
         if (cyc != 1 + TO) begin
            errors++;
            $display("FAIL timeout_lat: got %0d want %0d", cyc, 1 + TO);
         end
      end
      step();
      set_req(0, 1'b0, 1'b0, '0, '0);
      slave_hang = 1'b0;
      @(negedge clk);
      checks++;
      if ({timeout, m_psel} !== 2'b00) begin
         errors++;
         $display("FAIL timeout_pulse: timeout/psel got %b want 00", {timeout, m_psel});
      end
      step();
      // Next request is served normally.
      slave_rdata = 32'h0000_0077;
      set_req(1, 1'b1, 1'b0, 32'h0000_0018, '0);
      exp_q.push_back(make_exp(1, 1'b0, 1'b0, 8'h18, 32'h0000_0077));
      wait_resp(10, got, cyc);
      exp = exp_q.pop_front();
      checks++;
      if (!got || cyc != 2) begin
         errors++;
         $display("FAIL after_timeout: got pready=%0d at %0d want at 2", got, cyc);
      end else begin
         obs = observe();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL after_timeout_resp: got %h want %h", obs, exp);
         end
      end
      step();
      set_req(1, 1'b0, 1'b0, '0, '0);
      step();
   endtask

   task automatic test_slave_err();
      logic [SBW-1:0] obs, exp;
      bit             got;
      int             cyc;
      slave_err   = 1'b1;
      slave_rdata = 32'h0000_003C;
      set_req(0, 1'b1, 1'b0, 32'h0000_001C, '0);
      exp_q.push_back(make_exp(0, 1'b1, 1'b0, 8'h1C, 32'h0000_003C));
      wait_resp(10, got, cyc);
      exp = exp_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL slave_err: no pready within 10 cycles");
      end else begin
         obs = observe();
         if (obs !== exp) begin
            errors++;
            $display("FAIL slave_err: got %h want %h", obs, exp);
         end
      end
      step();
      set_req(0, 1'b0, 1'b0, '0, '0);
      slave_err = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      logic [SBW-1:0] obs, exp;
      bit             got;
      int             cyc;
      slave_hang = 1'b1;
      set_req(1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0099);
      // IDLE, SETUP, ACCESS, ACCESS
      for (int i = 0; i < 4; i++) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_pready, timeout} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_no_resp: pready/timeout got %b want 000", {req_pready, timeout});
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      obs = observe();
      checks++;
      if ({obs, grant, m_psel, m_penable} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h grant %b psel %b penable %b",
                  obs, grant, m_psel, m_penable);
      end
      @(posedge clk);
      #1;
      rst         = 1'b0;
      slave_hang  = 1'b0;
      slave_rdata = 32'h0000_0042;
      exp_q.push_back(make_exp(1, 1'b0, 1'b0, 8'h20, 32'h0000_0042));
      wait_resp(10, got, cyc);
      exp = exp_q.pop_front();
      checks++;
      if (!got || cyc != 2) begin
         errors++;
         $display("FAIL reset_mid_regrant: got pready=%0d at %0d want at 2", got, cyc);
      end else begin
         obs = observe();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_resp: got %h want %h", obs, exp);
         end
      end
      step();
      set_req(1, 1'b0, 1'b0, '0, '0);
      step();
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      req_psel    = '0;
      req_penable = '0;
      req_pwrite  = '0;
      req_paddr   = '0;
      req_pwdata  = '0;
      slave_wait  = 0;
      slave_hang  = 1'b0;
      slave_err   = 1'b0;
      slave_rdata = '0;

      test_reset();
      test_single_write();
      test_contention();
      test_wait_read();
      test_timeout();
      test_slave_err();
      test_reset_mid();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
